// File: rtl/i3c_timer_bank.sv
// Bank of NUM_CH independent down-counting timers sharing one tick source.
// Optional shared tick prescaler is built when I3C_TIMER_PRESCALER_EN is defined.
//
// state | meaning
// IDLE  | channel stopped, counter frozen, busy_o=0
// RUN   | channel counting down on enabled ticks, busy_o=1
module i3c_timer_bank #(
    parameter int NUM_CH  = 4,
    parameter int CNTR_W  = 16,
    parameter int PRESC_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          load_i,
    input  logic [NUM_CH*CNTR_W-1:0]   init_value_i,
    input  logic [NUM_CH-1:0]          mode_i,
    input  logic [NUM_CH-1:0]          enable_i,
    input  logic [NUM_CH-1:0]          stop_i,
`ifdef I3C_TIMER_PRESCALER_EN
    input  logic [PRESC_W-1:0]         prescale_i,
`endif
    output logic [NUM_CH-1:0]          busy_o,
    output logic [NUM_CH-1:0]          done_o,
    output logic [NUM_CH*CNTR_W-1:0]   cnt_o
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    if (NUM_CH < 1 || NUM_CH > 16 || CNTR_W < 2 || CNTR_W > 32 || PRESC_W < 1) begin : g_bad_param
        $error("i3c_timer_bank: parameter out of range");
    end

    state_e                         state_q [NUM_CH];
    state_e                         state_d [NUM_CH];
    logic [NUM_CH-1:0][CNTR_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0][CNTR_W-1:0]  rel_q, rel_d;
    logic [NUM_CH-1:0]              mode_q, mode_d;
    logic [NUM_CH-1:0]              done_q, done_d;
    logic                           tick;

`ifdef I3C_TIMER_PRESCALER_EN
    logic [PRESC_W-1:0] presc_q, presc_d;

    // >= keeps the prescaler bounded if prescale_i is lowered mid-count
    always_comb begin
        tick    = (presc_q == prescale_i);
        presc_d = (presc_q >= prescale_i) ? '0 : presc_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) presc_q <= '0;
        else     presc_q <= presc_d;
    end
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        cnt_d  = cnt_q;
        rel_d  = rel_q;
        mode_d = mode_q;
        done_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            state_d[c] = state_q[c];
            if (load_i[c]) begin
                cnt_d[c]   = init_value_i[c*CNTR_W +: CNTR_W];
                rel_d[c]   = init_value_i[c*CNTR_W +: CNTR_W];
                mode_d[c]  = mode_i[c];
                state_d[c] = RUN;
            end else if (stop_i[c]) begin
                state_d[c] = IDLE;
            end else if (state_q[c] == RUN && tick && enable_i[c]) begin
                if (cnt_q[c] != '0) begin
                    cnt_d[c] = cnt_q[c] - 1'b1;
                end else begin
                    done_d[c] = 1'b1;
                    if (mode_q[c]) cnt_d[c] = rel_q[c];
                    else           state_d[c] = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) state_q[c] <= IDLE;
            cnt_q  <= '0;
            rel_q  <= '0;
            mode_q <= '0;
            done_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) state_q[c] <= state_d[c];
            cnt_q  <= cnt_d;
            rel_q  <= rel_d;
            mode_q <= mode_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        busy_o = '0;
        for (int c = 0; c < NUM_CH; c++) busy_o[c] = (state_q[c] == RUN);
    end

    assign done_o = done_q;
    assign cnt_o  = cnt_q;

endmodule

// File: doc/i3c_timer_bank.md
I3C_TIMER_BANK -- requirements
Module: i3c_timer_bank

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, giving the number of independent timer channels (1..16).
REQ-002 The block SHALL have parameter CNTR_W, default 16, giving the width of each channel counter (2..32).
REQ-003 The block SHALL have parameter PRESC_W, default 8, giving the width of the shared prescaler.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port load_i, input, NUM_CH bits: per-channel load/start strobe.
REQ-007 The block SHALL have port init_value_i, input, NUM_CH*CNTR_W bits: per-channel start value; channel c uses bits [c*CNTR_W +: CNTR_W].
REQ-008 The block SHALL have port mode_i, input, NUM_CH bits: per-channel mode sampled on load (0 = one-shot, 1 = auto-reload).
REQ-009 The block SHALL have port enable_i, input, NUM_CH bits: per-channel count enable (0 = pause and hold).
REQ-010 The block SHALL have port stop_i, input, NUM_CH bits: per-channel abort strobe.
REQ-011 The block SHALL have port prescale_i, input, PRESC_W bits: tick divider, present only with I3C_TIMER_PRESCALER_EN.
REQ-012 The block SHALL have port busy_o, output, NUM_CH bits: channel is in RUN.
REQ-013 The block SHALL have port done_o, output, NUM_CH bits: one-cycle registered expiry pulse.
REQ-014 The block SHALL have port cnt_o, output, NUM_CH*CNTR_W bits: current counter values, same packing as init_value_i.

Function
REQ-015 Each channel SHALL hold state IDLE or RUN, a CNTR_W counter, a CNTR_W reload register and a mode bit.
REQ-016 When load_i[c]=1, on the next edge the channel SHALL set counter = reload = init_value, mode = mode_i[c] and state = RUN, regardless of current state.
REQ-017 When stop_i[c]=1 and load_i[c]=0, on the next edge the channel SHALL go to IDLE, hold the counter value, and SHALL NOT pulse done_o.
REQ-018 A channel in RUN SHALL count only on edges where tick=1 and enable_i[c]=1; otherwise it SHALL hold its counter.
REQ-019 On a counting edge with counter != 0, the channel SHALL decrement the counter by 1.
REQ-020 On a counting edge with counter == 0, the channel SHALL set done_o[c]=1 for exactly the following cycle; one-shot goes to IDLE with counter 0, auto-reload reloads the counter from reload and stays in RUN.
REQ-021 After a load of N, the channel SHALL assert done_o after N+1 counting edges; in auto-reload the period is N+1 ticks, and N=0 gives done every tick.
REQ-022 Priority per channel SHALL be load > stop > count; a load on the same edge as expiry SHALL suppress that done pulse.
REQ-023 done_o[c] SHALL be 0 on every cycle not defined by REQ-020.
REQ-024 busy_o[c] SHALL be 1 exactly when state is RUN.
REQ-025 The counter SHALL never wrap below 0.
REQ-026 Channels SHALL be fully independent except for the shared tick.

Reset
REQ-027 While rst=1, all channels SHALL go to IDLE with counter, reload and mode 0, and busy_o=0, done_o=0, cnt_o=0.
REQ-028 Reset asserted mid-count SHALL abort the count without a done pulse; the prescaler SHALL clear to 0.
REQ-029 Inputs SHALL be ignored on edges where rst=1.

Configuration
REQ-030 When I3C_TIMER_PRESCALER_EN is defined, a PRESC_W prescaler SHALL count 0..prescale_i and assert tick on the edge where it equals prescale_i, then wrap to 0, giving one tick per prescale_i+1 cycles; load_i SHALL NOT reset it.
REQ-031 When I3C_TIMER_PRESCALER_EN is undefined, prescale_i and the prescaler SHALL be absent and tick SHALL be constant 1.

Verification
REQ-032 The bench SHALL cover: no prescaler, ch0 load 3, one-shot, enable=1 -> cnt_o 3,2,1,0, done_o pulses on the 4th counting edge, then busy_o=0.
REQ-033 The bench SHALL cover: ch1 load 2, auto-reload -> done_o every 3 cycles, busy_o stays 1, cnt_o sequence 2,1,0,2,1,0.
REQ-034 The bench SHALL cover: ch0 running at 5, enable=0 for 4 cycles, then stop_i -> counter holds 5, then IDLE, and done_o is never asserted.
REQ-035 The bench SHALL cover: load_i and stop_i on the same edge, and load_i on the expiry edge -> load wins, the counter equals the new value, and no done pulse occurs.
REQ-036 The bench SHALL cover: with the macro, prescale_i=2 and load 1 -> decrements only every 3rd cycle, done after 2 ticks.
REQ-037 The bench SHALL cover: rst=1 mid-count on all channels -> next cycle busy_o=0, cnt_o=0, done_o=0.
